// File: rtl/xsleena_snd_mixer.sv
// Sound mixer for the two YM2203 outputs.
// Holds each input between its strobes, resamples both onto one output rate,
// sums, applies gain, saturates, runs an optional DC blocker and queues the
// result in a small ready/valid FIFO.
// Ports:
//   clk, RSTn              clock, async active-low reset
//   snd1/snd2, sample1/2   signed inputs and their one-cycle valid strobes
//   pause_rq               freezes output sample generation
//   gain                   unsigned Q2.2 volume (4 = unity)
//   dcb_en                 enables the DC blocker
//   out_ready/out_valid    sink handshake; out_data is the FIFO head
//   clip, overflow         sticky saturation / dropped-sample flags
module xsleena_snd_mixer #(
  parameter int unsigned OUT_DIV    = 1000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DCB_SHIFT  = 10
) (
  input  logic               clk,
  input  logic               RSTn,
  input  logic signed [15:0] snd1,
  input  logic signed [15:0] snd2,
  input  logic               sample1,
  input  logic               sample2,
  input  logic               pause_rq,
  input  logic [3:0]         gain,
  input  logic               dcb_en,
  input  logic               out_ready,
  output logic               out_valid,
  output logic signed [15:0] out_data,
  output logic               clip,
  output logic               overflow
);

  localparam int unsigned CW = $clog2(OUT_DIV);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic signed [15:0] h1, h2;
  logic [CW-1:0]      cnt;
  logic               tick_c;

  logic signed [16:0] s1;
  logic               v1;
  logic signed [15:0] p2;
  logic               v2;
  logic signed [15:0] y3, xp, yp;
  logic               v3;

  logic signed [21:0] prod_c, scl_c;
  logic signed [15:0] p_sat_c;
  logic               clamp2_c;
  logic signed [17:0] xe_c, xpe_c, ype_c, y_c;
  logic signed [15:0] y_sat_c;
  logic               clamp3_c;

  logic signed [15:0] mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr, wr_ptr_n_c, rd_ptr_n_c;
  logic               full_c, pop_c, push_c, drop_c, empty_n_c;
  logic signed [15:0] head_n_c;

  assign tick_c = !pause_rq && (cnt == CW'(OUT_DIV - 1));

  // Sample-and-hold of each input between its strobes
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      h1 <= '0;
      h2 <= '0;
    end else begin
      if (sample1) h1 <= snd1;
      if (sample2) h2 <= snd2;
    end
  end

  // Output-rate divider, frozen while paused
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (!pause_rq) begin
      cnt <= tick_c ? '0 : cnt + CW'(1);
    end
  end

  // Gain scaling and first saturation; 22 bits cover 17-bit sum times 15
  always_comb begin
    prod_c   = $signed({{5{s1[16]}}, s1}) * $signed({18'd0, gain});
    scl_c    = prod_c >>> 2;
    clamp2_c = 1'b0;
    p_sat_c  = scl_c[15:0];
    if (scl_c > 22'sd32767) begin
      p_sat_c  = 16'sh7fff;
      clamp2_c = 1'b1;
    end else if (scl_c < -22'sd32768) begin
      p_sat_c  = -16'sh8000;
      clamp2_c = 1'b1;
    end
  end

  // DC blocker y = x - xp + yp - yp/2^DCB_SHIFT in 18 bits, then saturate
  always_comb begin
    xe_c     = $signed({{2{p2[15]}}, p2});
    xpe_c    = $signed({{2{xp[15]}}, xp});
    ype_c    = $signed({{2{yp[15]}}, yp});
    y_c      = xe_c - xpe_c + ype_c - (ype_c >>> DCB_SHIFT);
    clamp3_c = 1'b0;
    y_sat_c  = y_c[15:0];
    if (y_c > 18'sd32767) begin
      y_sat_c  = 16'sh7fff;
      clamp3_c = 1'b1;
    end else if (y_c < -18'sd32768) begin
      y_sat_c  = -16'sh8000;
      clamp3_c = 1'b1;
    end
  end

  // Three-stage pipeline: sum, scale, filter; valid bit travels alongside
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      s1   <= '0;
      v1   <= 1'b0;
      p2   <= '0;
      v2   <= 1'b0;
      y3   <= '0;
      v3   <= 1'b0;
      xp   <= '0;
      yp   <= '0;
      clip <= 1'b0;
    end else begin
      v1 <= tick_c;
      if (tick_c) s1 <= {h1[15], h1} + {h2[15], h2};
      v2 <= v1;
      if (v1) p2 <= p_sat_c;
      v3 <= v2;
      if (v2) begin
        xp <= p2;
        if (dcb_en) begin
          y3 <= y_sat_c;
          yp <= y_sat_c;
        end else begin
          // Tracking x keeps the filter step-free when re-enabled
          y3 <= p2;
          yp <= p2;
        end
      end
      clip <= clip | (v1 & clamp2_c) | (v2 & dcb_en & clamp3_c);
    end
  end

  // FIFO next-state; a push into a full FIFO only succeeds alongside a pop
  always_comb begin
    full_c     = (wr_ptr - rd_ptr) == PW'(FIFO_DEPTH);
    pop_c      = out_valid & out_ready;
    push_c     = v3 & (~full_c | pop_c);
    drop_c     = v3 & full_c & ~pop_c;
    wr_ptr_n_c = wr_ptr + PW'(push_c);
    rd_ptr_n_c = rd_ptr + PW'(pop_c);
    empty_n_c  = (wr_ptr_n_c == rd_ptr_n_c);
    // The slot being written becomes the head only when it is the sole entry
    if (push_c && (wr_ptr[AW-1:0] == rd_ptr_n_c[AW-1:0])) begin
      head_n_c = y3;
    end else begin
      head_n_c = mem[rd_ptr_n_c[AW-1:0]];
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr[AW-1:0]] <= y3;
  end

  // FIFO pointers and registered head/valid/overflow
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_n_c;
      rd_ptr    <= rd_ptr_n_c;
      out_valid <= ~empty_n_c;
      if (!empty_n_c) out_data <= head_n_c;
      overflow  <= overflow | drop_c;
    end
  end

endmodule
